// File: rtl/wavefront_feed_sched_if.sv
// Handshake and bus bundle between the wavefront feed scheduler and its
// line-buffer / systolic-array neighbours.
interface wavefront_feed_sched_if #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 10
);
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] img_w;
  logic [DATA_W-1:0] img_h;
  logic [ADDR_W-1:0] base_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              done;
  logic              err;
  logic              skew_valid;
  logic              win_valid;
  logic              win_last;

  modport master (
    output start, abort, img_w, img_h, base_addr,
    input  rd_en, rd_addr, busy, done, err, skew_valid, win_valid, win_last
  );

  modport slave (
    input  start, abort, img_w, img_h, base_addr,
    output rd_en, rd_addr, busy, done, err, skew_valid, win_valid, win_last
  );
endinterface

// File: rtl/wavefront_feed_sched.sv
// Column-feed scheduler for a 5-line wavefront delay block: walks the image one
// 5-row band at a time and tracks when full 5x5 windows reach the array.
//
// state | meaning
// IDLE  | waiting for start; config latched on a start request
// FEED  | one column read per cycle for the current band
// DRAIN | no reads; lets the skewed band flush through the delay block
// DONE  | one-cycle frame completion pulse
module wavefront_feed_sched #(
  parameter int DATA_W          = 6,
  parameter int ADDR_W          = 10,
  parameter int WAVEFRONT_DELAY = 4,
  parameter int MEM_LAT         = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  wavefront_feed_sched_if.slave bus
);

  localparam int FLUSH = MEM_LAT + 4 * WAVEFRONT_DELAY + 1;
  localparam int CNT_W = (FLUSH > 1) ? $clog2(FLUSH) : 1;
  localparam logic [CNT_W-1:0]  FLUSH_LOAD = CNT_W'(FLUSH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [DATA_W-1:0] ONE        = DATA_W'(1);
  localparam logic [DATA_W-1:0] MIN_DIM    = DATA_W'(5);
  localparam logic [DATA_W-1:0] WIN_COL    = DATA_W'(4);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] img_w_q;
  logic [DATA_W-1:0] img_h_q;
  logic [ADDR_W-1:0] band_base;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] oy_q;
  logic [CNT_W-1:0]  drain_cnt;
  logic              err_q;
  logic [FLUSH-1:0]  vld_sr;
  logic [DATA_W-1:0] tag_sr [FLUSH];

  logic cfg_ok;
  logic start_ok;
  logic col_last;
  logic band_last;
  logic drain_end;
  logic rd_en;
  logic skew_valid;

  assign cfg_ok    = (bus.img_w >= MIN_DIM) && (bus.img_h >= MIN_DIM);
  assign start_ok  = bus.start && !bus.abort;
  assign col_last  = (x_q == img_w_q - ONE);
  assign band_last = (oy_q == img_h_q - MIN_DIM);
  assign drain_end = (drain_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok && cfg_ok) state_next = FEED;
      FEED:    if (col_last) state_next = DRAIN;
      DRAIN:   if (drain_end) state_next = band_last ? DONE : FEED;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.abort) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_w_q   <= '0;
      img_h_q   <= '0;
      band_base <= '0;
      x_q       <= '0;
      oy_q      <= '0;
      drain_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            img_w_q   <= bus.img_w;
            img_h_q   <= bus.img_h;
            band_base <= bus.base_addr;
            x_q       <= '0;
            oy_q      <= '0;
            err_q     <= !cfg_ok;
          end
        end
        FEED: begin
          x_q       <= x_q + ONE;
          drain_cnt <= FLUSH_LOAD;
        end
        DRAIN: begin
          if (!drain_end) begin
            drain_cnt <= drain_cnt - CNT_ONE;
          end else if (!band_last) begin
            oy_q      <= oy_q + ONE;
            band_base <= band_base + ADDR_W'(img_w_q);
            x_q       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Valid bit and column tag ride the same delay line so window flags line up
  // with the data leaving line_4 of the delay block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < FLUSH; i++) tag_sr[i] <= '0;
    end else if (bus.abort) begin
      vld_sr <= '0;
      for (int i = 0; i < FLUSH; i++) tag_sr[i] <= '0;
    end else begin
      vld_sr    <= {vld_sr[FLUSH-2:0], rd_en};
      tag_sr[0] <= x_q;
      for (int i = 1; i < FLUSH; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  assign rd_en      = (state == FEED);
  assign skew_valid = vld_sr[FLUSH-1];

  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = rd_en ? (band_base + ADDR_W'(x_q)) : '0;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.err        = err_q;
  assign bus.skew_valid = skew_valid;
  assign bus.win_valid  = skew_valid && (tag_sr[FLUSH-1] >= WIN_COL);
  assign bus.win_last   = skew_valid && (tag_sr[FLUSH-1] == img_w_q - ONE);

endmodule

// File: tb/tb_wavefront_feed_sched.sv
// Scoreboard bench for wavefront_feed_sched: a frame-level model pushes
// timestamped expected reads, window flags and pulses; a monitor checks them.
module tb_wavefront_feed_sched;
  localparam int DATA_W = 6;
  localparam int ADDR_W = 10;
  localparam int FLUSH  = 1 + 4 * 4 + 1;

  typedef struct { int t; int addr; } rd_ev_t;
  typedef struct { int t; bit win; bit last; } sk_ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  wavefront_feed_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wavefront_feed_sched #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAVEFRONT_DELAY(4), .MEM_LAT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  rd_ev_t rd_q[$];
  sk_ev_t sk_q[$];
  int     done_q[$];
  int     err_q[$];
  int     busy_start = 1;
  int     busy_end = 0;

  int n_rd, n_sk, n_win, n_last, n_done, n_busy, first_rd, first_sk, done_cyc;
  int cur_w = 8, cur_h = 6, cur_b = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int outs_bits();
    return int'({bus.rd_en, |bus.rd_addr, bus.busy, bus.done, bus.err,
                 bus.skew_valid, bus.win_valid, bus.win_last});
  endfunction

  // Frame-level reference: a legal start in cycle n reads band b column x in
  // cycle n+1+b*(w+FLUSH)+x; each read reappears as skew_valid FLUSH later.
  task automatic model_cycle(input bit st, input bit ab, input int w, input int h,
                             input int base, input int n);
    int period, bands, t0;
    if (ab) begin
      while (rd_q.size() > 0 && rd_q[$].t > n) void'(rd_q.pop_back());
      while (sk_q.size() > 0 && sk_q[$].t > n) void'(sk_q.pop_back());
      while (done_q.size() > 0 && done_q[$] > n) void'(done_q.pop_back());
      if (busy_end > n) busy_end = n;
    end else if (st && n > busy_end) begin
      if (w < 5 || h < 5) begin
        err_q.push_back(n + 1);
      end else begin
        period = w + FLUSH;
        bands  = h - 4;
        t0     = n + 1;
        busy_start = t0;
        busy_end   = t0 + bands * period;
        for (int b = 0; b < bands; b++)
          for (int x = 0; x < w; x++) begin
            rd_q.push_back('{t0 + b * period + x, (base + b * w + x) % 1024});
            sk_q.push_back('{t0 + b * period + x + FLUSH, (x >= 4), (x == w - 1)});
          end
        done_q.push_back(busy_end);
      end
    end
  endtask

  task automatic drive(input bit st, input bit ab, input int w, input int h, input int base);
    @(posedge clk);
    #1;
    cur_w = w; cur_h = h; cur_b = base;
    bus.start     = st;
    bus.abort     = ab;
    bus.img_w     = w[DATA_W-1:0];
    bus.img_h     = h[DATA_W-1:0];
    bus.base_addr = base[ADDR_W-1:0];
    model_cycle(st, ab, w, h, base, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, cur_w, cur_h, cur_b);
  endtask

  task automatic finish_frame();
    int guard = 0;
    while (cyc <= busy_end && guard < 3000) begin
      idle(1);
      guard++;
    end
    chk("frame_timeout", int'(guard < 3000), 1);
    idle(2);
  endtask

  task automatic clear_counters();
    n_rd = 0; n_sk = 0; n_win = 0; n_last = 0; n_done = 0; n_busy = 0;
    first_rd = -1; first_sk = -1; done_cyc = -1;
  endtask

  // Monitor: compares DUT outputs against the scoreboard every cycle.
  int  mc;
  bit  e_rd, e_sk, e_done, e_err;
  initial forever begin
    @(negedge clk);
    mc = cyc;
    if (!rst_n) begin
      chk("reset_outputs", outs_bits(), 0);
    end else begin
      e_rd = rd_q.size() > 0 && rd_q[0].t == mc;
      chk("rd_en", bus.rd_en, e_rd);
      if (e_rd) begin
        if (bus.rd_en) chk("rd_addr", bus.rd_addr, rd_q[0].addr);
        void'(rd_q.pop_front());
      end
      e_sk = sk_q.size() > 0 && sk_q[0].t == mc;
      chk("skew_valid", bus.skew_valid, e_sk);
      if (e_sk) begin
        if (bus.skew_valid) begin
          chk("win_valid", bus.win_valid, sk_q[0].win);
          chk("win_last", bus.win_last, sk_q[0].last);
        end
        void'(sk_q.pop_front());
      end else begin
        chk("win_flags_idle", int'({bus.win_valid, bus.win_last}), 0);
      end
      e_done = done_q.size() > 0 && done_q[0] == mc;
      chk("done", bus.done, e_done);
      if (e_done) void'(done_q.pop_front());
      e_err = err_q.size() > 0 && err_q[0] == mc;
      chk("err", bus.err, e_err);
      if (e_err) void'(err_q.pop_front());
      chk("busy", bus.busy, int'(mc >= busy_start && mc <= busy_end));
      if (bus.rd_en) begin if (n_rd == 0) first_rd = mc; n_rd++; end
      if (bus.skew_valid) begin if (n_sk == 0) first_sk = mc; n_sk++; end
      if (bus.win_valid) n_win++;
      if (bus.win_last) n_last++;
      if (bus.done) begin n_done++; done_cyc = mc; end
      if (bus.busy) n_busy++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int s, w, h, b, abort_at;
  initial begin
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.img_w = '0; bus.img_h = '0; bus.base_addr = '0;
    clear_counters();
    repeat (3) @(posedge clk);
    #1 chk("reset_state", outs_bits(), 0);
    rst_n = 1'b1;

    // Nominal 8x6 frame at 0x100
    clear_counters();
    drive(1'b1, 1'b0, 8, 6, 'h100);
    finish_frame();
    chk("skew_latency", first_sk - first_rd, 18);
    chk("done_latency", done_cyc - first_rd, 52);
    chk("rd_count", n_rd, 16);
    chk("win_count", n_win, 8);
    chk("last_count", n_last, 2);
    chk("done_count", n_done, 1);

    // Illegal width
    clear_counters();
    drive(1'b1, 1'b0, 4, 10, 'h000);
    idle(5);
    chk("illegal_no_rd", n_rd, 0);
    chk("illegal_no_busy", n_busy, 0);

    // start and abort together in IDLE
    clear_counters();
    drive(1'b1, 1'b1, 8, 6, 'h000);
    idle(4);
    chk("abort_wins_no_busy", n_busy, 0);

    // Abort in the 3rd DRAIN cycle of band 0
    clear_counters();
    drive(1'b1, 1'b0, 8, 6, 'h020);
    s = cyc;
    idle(10);
    drive(1'b0, 1'b1, 8, 6, 'h020);
    chk("abort_cycle", cyc - s, 11);
    drive(1'b0, 1'b0, 8, 6, 'h020);
    chk("abort_idle_busy", bus.busy, 0);
    idle(25);
    chk("abort_no_skew", n_sk, 0);
    chk("abort_no_done", n_done, 0);

    // Stray start during FEED
    clear_counters();
    drive(1'b1, 1'b0, 8, 6, 'h040);
    idle(3);
    drive(1'b1, 1'b0, 20, 20, 'h200);
    finish_frame();
    chk("stray_rd_count", n_rd, 16);
    chk("stray_done_count", n_done, 1);

    // One-cycle reset mid-FEED, then restart on the first edge (address wraps)
    drive(1'b1, 1'b0, 8, 6, 'h000);
    idle(4);
    @(posedge clk);
    #1;
    rst_n = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    rd_q.delete(); sk_q.delete(); done_q.delete(); err_q.delete();
    busy_start = 1; busy_end = 0;
    #1 chk("async_reset_outputs", outs_bits(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_counters();
    cur_w = 8; cur_h = 6; cur_b = 'h3FC;
    bus.start = 1'b1; bus.img_w = 6'd8; bus.img_h = 6'd6; bus.base_addr = 10'h3FC;
    model_cycle(1'b1, 1'b0, 8, 6, 'h3FC, cyc);
    finish_frame();
    chk("post_reset_rd_count", n_rd, 16);
    chk("post_reset_done", n_done, 1);

    // Randomised frames with stray starts and occasional aborts
    for (int f = 0; f < 25; f++) begin
      w = $urandom_range(3, 12);
      h = $urandom_range(3, 8);
      b = $urandom_range(0, 1023);
      drive(1'b1, 1'b0, w, h, b);
      abort_at = (f % 4 == 3) ? cyc + $urandom_range(1, 60) : -1;
      for (int g = 0; g < 3000 && cyc <= busy_end; g++) begin
        if (cyc + 1 == abort_at)
          drive(1'b0, 1'b1, w, h, b);
        else if ($urandom_range(0, 29) == 0)
          drive(1'b1, 1'b0, $urandom_range(3, 40), $urandom_range(3, 40), $urandom_range(0, 1023));
        else
          drive(1'b0, 1'b0, w, h, b);
      end
      idle($urandom_range(2, 4));
    end

    idle(3);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("sk_q_empty", sk_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wavefront_feed_sched.md
WAVEFRONT_FEED_SCHED -- requirements
Module: wavefront_feed_sched

Interface
REQ-001 Parameter: DATA_W, default 6, bit width of the image dimension fields.
REQ-002 Parameter: ADDR_W, default 10, bit width of read addresses.
REQ-003 Parameter: WAVEFRONT_DELAY, default 4, per-line skew step of the downstream 5-line delay block.
REQ-004 Parameter: MEM_LAT, default 1, cycles from rd_en to read data arriving at the delay block inputs.
REQ-005 Port: clk, input, 1, clock; all logic is rising-edge.
REQ-006 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port: start, input, 1, one-cycle frame start request.
REQ-008 Port: abort, input, 1, synchronous frame cancel.
REQ-009 Port: img_w, input, DATA_W, image width in pixels.
REQ-010 Port: img_h, input, DATA_W, image height in pixels.
REQ-011 Port: base_addr, input, ADDR_W, address of pixel (0,0).
REQ-012 Port: rd_en, output, 1, line-buffer column read strobe.
REQ-013 Port: rd_addr, output, ADDR_W, address of the top-row pixel of the current column.
REQ-014 Port: busy, output, 1, high while not IDLE.
REQ-015 Port: done, output, 1, one-cycle frame completion pulse.
REQ-016 Port: err, output, 1, one-cycle pulse on an illegal config.
REQ-017 Port: skew_valid, output, 1, high when line_4 of the delay block carries valid data.
REQ-018 Port: win_valid, output, 1, high when a full 5x5 window is present at the array.
REQ-019 Port: win_last, output, 1, high on the last window of a band.

Function
REQ-020 The FSM SHALL have the states IDLE, FEED, DRAIN and DONE, all registered.
REQ-021 In IDLE, start SHALL latch img_w, img_h and base_addr; later input changes are ignored until the next IDLE.
REQ-022 If the latched img_w<5 or img_h<5 at start, the block SHALL pulse err on the next cycle and remain in IDLE.
REQ-023 A legal start SHALL move IDLE->FEED, with row oy=0, column x=0 and band_base=base_addr.
REQ-024 In FEED, rd_en=1 every cycle and rd_addr=band_base+x; x increments each cycle.
REQ-025 FEED SHALL move to DRAIN after the cycle with x=img_w-1; rd_en=0 in DRAIN.
REQ-026 DRAIN SHALL last exactly FLUSH=MEM_LAT+4*WAVEFRONT_DELAY+1 cycles, which is 18 at the defaults.
REQ-027 At the end of DRAIN, if oy<img_h-5: oy++, band_base+=img_w, x=0, and the FSM SHALL return to FEED.
REQ-028 At the end of DRAIN, if oy=img_h-5, the FSM SHALL move to DONE.
REQ-029 DONE SHALL last one cycle with done=1, then move to IDLE.
REQ-030 start SHALL be ignored in every state except IDLE.
REQ-031 abort SHALL force IDLE on the next edge from any state, with no done pulse; the tracking pipeline SHALL be cleared in the same edge.
REQ-032 If start and abort are both high in IDLE, abort wins and no frame starts.
REQ-033 skew_valid SHALL equal rd_en delayed by MEM_LAT+4*WAVEFRONT_DELAY+1 cycles, via a shift register.
REQ-034 A column tag SHALL travel alongside skew_valid in the same pipeline.
REQ-035 win_valid SHALL equal skew_valid AND (tagged column >= 4).
REQ-036 win_last SHALL equal skew_valid AND (tagged column = img_w-1).
REQ-037 Address arithmetic SHALL be modulo 2^ADDR_W and wrap silently.
REQ-038 busy SHALL be 1 in FEED, DRAIN and DONE.

Reset
REQ-039 While rst_n=0, the block SHALL be in IDLE, all counters and pipeline bits SHALL be 0, and every output SHALL be 0.
REQ-040 After rst_n deasserts, the block SHALL accept start on the first rising edge.
REQ-041 Reset asserted mid-frame SHALL discard the frame with no done pulse.

Verification
REQ-042 img_w=8, img_h=6, base=0x100, defaults -> rd_addr 0x100..0x107, then 0x108..0x10F, 18 idle cycles after each band, done exactly 52 cycles after FEED entry.
REQ-043 The same run -> the first skew_valid 18 cycles after the first rd_en, win_valid 4 per band, win_last on the 8th skew_valid of each band.
REQ-044 img_w=4, img_h=10 -> err one cycle after start, rd_en never asserted, busy stays 0.
REQ-045 abort in the 3rd DRAIN cycle of band 0 -> IDLE next cycle, no done, skew_valid 0 from the next cycle.
REQ-046 start pulsed during FEED with img_w=20 -> ignored, and the original 8-wide frame completes unchanged.
REQ-047 rst_n low for 1 cycle mid-FEED -> all outputs 0 at once; a new start after release runs a normal frame.
